// File: rtl/memory_responder.sv
// memory_responder: byte-wide main memory behind a 16-bit load/store port.
// Each request is served as two byte operations, little-endian:
// low byte at a0, then high byte at a1 = a0+1 (wrapping).
// After reset the array is zero-filled one byte per cycle before traffic
// is accepted.
// Timing: if the handshake is in cycle 0, then LO is in cycle 1, HI is in
// cycle 2, and RESP (rsp_valid high) is in cycle 3.
module memory_responder #(
  parameter int MEM_SIZE = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_program,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        clr_busy
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [AW-1:0] LAST = AW'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LO,
    S_HI,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem [MEM_SIZE];

  logic [AW-1:0] clr_ptr_q;
  logic [AW-1:0] addr_q;    // a0, upper MAR bits already dropped
  logic [AW-1:0] addr_hi;   // a1, wraps at the top of the array
  logic          we_q;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata_q;

  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rd_byte;

  // MAR bits above the array size are aliased away on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  assign addr_hi   = addr_q + AW'(1);
  assign req_ready = (state_q == S_IDLE) && !halt_program;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign clr_busy  = (state_q == S_CLEAR);
  assign rsp_rdata = rdata_q;

  // Asynchronous byte read; HI reads the upper byte, all other states the lower.
  assign rd_byte = mem[(state_q == S_HI) ? addr_hi : addr_q];

  // State register; reset always lands in the clear engine.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // Next-state logic: clear, then serialized lo/hi byte accesses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_ptr_q == LAST) state_d = S_IDLE;
      S_IDLE:  if (accept)            state_d = S_LO;
      S_LO:                           state_d = S_HI;
      S_HI:                           state_d = S_RESP;
      S_RESP:  if (rsp_ready)         state_d = S_IDLE;
      default:                        state_d = S_CLEAR;
    endcase
  end

  // Single memory write port shared by the clear engine and store bytes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = 8'h00;
    case (state_q)
      S_CLEAR: mem_we = 1'b1;
      S_LO: begin
        mem_we    = we_q;
        mem_waddr = addr_q;
        mem_wdata = wdata_q[7:0];
      end
      S_HI: begin
        mem_we    = we_q;
        mem_waddr = addr_hi;
        mem_wdata = wdata_q[15:8];
      end
      default: ;
    endcase
  end

  // Memory array; writes are suppressed while reset is held so a reset
  // landing in LO/HI cannot commit a byte on that edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Request latch, clear pointer and response assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == S_CLEAR) clr_ptr_q <= clr_ptr_q + AW'(1);
      if (accept) begin
        addr_q  <= req_addr[AW-1:0];
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      // Stores echo the written word; loads assemble it byte by byte.
      if (state_q == S_LO) rdata_q[7:0]  <= we_q ? wdata_q[7:0]  : rd_byte;
      if (state_q == S_HI) rdata_q[15:8] <= we_q ? wdata_q[15:8] : rd_byte;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed plus randomized checks of memory_responder
// (MEM_SIZE=256) against a byte-array reference model.
module tb_memory_responder;

  localparam int MS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_program = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        clr_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [MS];

  memory_responder #(.MEM_SIZE(MS)) dut (
    .clk          (clk),
    .rst          (rst),
    .halt_program (halt_program),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .clr_busy     (clr_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse, then time the zero-fill.
  task automatic do_reset(input string tag);
    int n;
    int bad;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check({tag, "_busy"},  clr_busy,  1);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_valid"}, rsp_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 16'h0000);
    n = 0;
    bad = 0;
    while (clr_busy && n < MS + 50) begin
      if (req_ready || rsp_valid) bad++;
      tick;
      n++;
    end
    check({tag, "_clr_len"},   n,   MS);
    check({tag, "_clr_quiet"}, bad, 0);
    check({tag, "_post_ready"}, req_ready, !halt_program);
    for (int i = 0; i < MS; i++) model[i] = 8'h00;
  endtask

  // Present a request, wait for acceptance, update the model.
  // Returns one cycle after the handshake cycle (the LO cycle).
  task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] exp);
    int n;
    int a0;
    int a1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) check("accept_timeout", n, 0);
    a0 = int'(addr) % MS;
    a1 = (a0 + 1) % MS;
    if (we) begin
      model[a0] = wd[7:0];
      model[a1] = wd[15:8];
      exp = wd;
    end else begin
      exp = {model[a1], model[a0]};
    end
    tick;
    req_valid = 1'b0;
  endtask

  // Wait for the response, hold it off for 'hold' cycles, then consume it.
  task automatic finish_rsp(input string tag, input logic [15:0] exp, input int lat0, input int hold);
    int lat;
    int bad;
    lat = lat0;
    bad = 0;
    while (!rsp_valid && lat < 20) begin
      if (req_ready) bad++;
      tick;
      lat++;
    end
    check({tag, "_lat"},  lat, 3);
    check({tag, "_data"}, rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick;
      if (!rsp_valid || rsp_rdata !== exp || req_ready) bad++;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check({tag, "_done"},  rsp_valid, 0);
    check({tag, "_ready"}, req_ready, !halt_program);
    check({tag, "_stable"}, bad, 0);
  endtask

  task automatic access(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd, input int hold);
    logic [15:0] exp;
    start_req(we, addr, wd, exp);
    finish_rsp(tag, exp, 1, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp;
    int bad;

    do_reset("rst0");
    access("clr_ld", 1'b0, 16'h0010, 16'h0, 0);

    // Round trip and overlapping load.
    access("rt_st",  1'b1, 16'h0020, 16'hBEEF, 0);
    access("rt_ld",  1'b0, 16'h0020, 16'h0, 0);
    access("rt_ld1", 1'b0, 16'h0021, 16'h0, 0);
    check("rt_ld1_val", rsp_rdata, 16'h00BE);

    // Wrap at the top byte and address aliasing.
    access("wr_st",  1'b1, 16'h00FF, 16'h1234, 0);
    access("wr_ld",  1'b0, 16'h01FF, 16'h0, 0);
    check("wr_ld_val", rsp_rdata, 16'h1234);
    access("wr_ld0", 1'b0, 16'h0000, 16'h0, 0);
    check("wr_ld0_val", rsp_rdata, 16'h0012);

    // Backpressure.
    access("bp_ld", 1'b0, 16'h0020, 16'h0, 10);

    // Halt in IDLE: a pending request is never accepted.
    halt_program = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 16'h0020;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (req_ready || rsp_valid) bad++;
    end
    check("halt_idle", bad, 0);
    req_valid = 1'b0;
    halt_program = 1'b0;
    tick;

    // Halt raised during HI of a store: store completes, nothing more accepted.
    start_req(1'b1, 16'h0030, 16'hCAFE, exp);
    tick;
    halt_program = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 16'h0030;
    finish_rsp("halt_st", exp, 2, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (req_ready || rsp_valid) bad++;
    end
    check("halt_no_accept", bad, 0);
    req_valid = 1'b0;
    halt_program = 1'b0;
    tick;
    access("halt_ld", 1'b0, 16'h0030, 16'h0, 0);
    check("halt_ld_val", rsp_rdata, 16'hCAFE);

    // Reset during HI of a store.
    start_req(1'b1, 16'h0040, 16'hAAAA, exp);
    tick;
    rsp_ready = 1'b1;
    do_reset("rst_hi");
    rsp_ready = 1'b0;
    access("rst_hi_ld", 1'b0, 16'h0040, 16'h0, 0);
    check("rst_hi_ld_val", rsp_rdata, 16'h0000);

    // Reset in RESP with rsp_ready high: reset wins.
    access("pre_st", 1'b1, 16'h0050, 16'h5A5A, 0);
    start_req(1'b0, 16'h0050, 16'h0, exp);
    tick;
    tick;
    check("resp_pre_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    do_reset("rst_resp");
    rsp_ready = 1'b0;
    access("rst_resp_ld", 1'b0, 16'h0050, 16'h0, 0);

    // Randomized traffic, addresses biased toward the wrap region.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 65535));
      else a = 16'(($urandom_range(0, 7) << 8) | (($urandom_range(0, 7) + 8'hFC) & 8'hFF));
      access("rnd", 1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-wide main-memory responder that services the 16-bit MAR/MBR accesses issued by the execute/memory stage of the accumulator CPU. It accepts one request at a time over a valid/ready handshake. It performs the access as two sequential byte operations, little-endian: low byte at MAR, high byte at MAR+1. It returns a 16-bit response over a second valid/ready handshake. After reset it zero-fills the whole array with a sequential clear engine before accepting traffic.

## Interface
- MEM_SIZE, 65536, memory depth in bytes; power of two, 4..65536
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- halt_program  in  1  when high, no new request is accepted; an in-flight access completes
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store 16-bit word, 0 = load 16-bit word
- req_addr  in  16  MAR; byte address of the low byte
- req_wdata  in  16  MBR for stores
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  16  loaded word (load) or stored word echoed (store)
- clr_busy  out  1  high while the zero-fill runs

## Operation
- States: CLEAR, IDLE, LO, HI, RESP.
- CLEAR:
  - Entered on rst from any state; the in-flight request is discarded and no response is issued.
  - Writes 8'h00 to byte clr_ptr and increments clr_ptr each cycle, from 0 to MEM_SIZE-1.
  - After writing MEM_SIZE-1, goes to IDLE.
- IDLE:
  - req_ready = !halt_program.
  - On req_valid && req_ready, latch addr, we and wdata, then go to LO.
- LO:
  - Load: capture mem[a0] into rsp_rdata[7:0].
  - Store: write req_wdata[7:0] to mem[a0].
  - Go to HI.
- HI:
  - Load: capture mem[a1] into rsp_rdata[15:8].
  - Store: write wdata[15:8] to mem[a1].
  - Go to RESP.
- RESP:
  - rsp_valid = 1 and rsp_rdata held stable.
  - On rsp_ready, go to IDLE.
  - For stores, rsp_rdata = latched wdata.
- Address arithmetic:
  - a0 = req_addr mod MEM_SIZE; upper address bits are ignored.
  - a1 = (a0 + 1) mod MEM_SIZE, so an access at the top byte wraps its high byte to byte 0.
- Only one access is in flight at a time. req_ready is 0 in every state except IDLE.
- halt_program is sampled only in IDLE. Asserting it in LO/HI/RESP does not abort the access.
- Load after store to the same or an overlapping address returns the new bytes. No stale-data window exists, because accesses are serialized.

## Timing
- Reset values:
  - req_ready 0, rsp_valid 0, rsp_rdata 16'h0000, clr_busy 1.
  - State CLEAR, clr_ptr 0.
- Clear duration: exactly MEM_SIZE cycles after the rst-deasserted edge. clr_busy falls and req_ready rises together, on the same edge.
- Accept at edge E0. rsp_valid is high from edge E0+3 (LO at E1, HI at E2, RESP at E3). Minimum latency is 3 cycles.
- Response consumed at edge Er (rsp_valid && rsp_ready). rsp_valid is 0 and req_ready is !halt_program after Er.
- Minimum spacing between accepted requests is 4 cycles.
- rsp_ready may be high before rsp_valid; it is ignored outside RESP.
- rst asserted in RESP with rsp_ready high: reset wins, no handshake completes, and rsp_valid is 0 next cycle.
- Memory writes take effect at the edge ending LO/HI; a read in the following state sees them.

## Test plan
- Reset/clear (MEM_SIZE=256): pulse rst one cycle -> clr_busy high exactly 256 cycles, req_ready 0 throughout. Then load 0x0010 -> rsp_rdata 16'h0000.
- Store/load round trip: store 16'hBEEF @0x0020, then load @0x0020 -> 16'hBEEF. Load @0x0021 -> 16'h??BE with low byte BE and high byte 00 (16'h00BE). rsp_valid rises 3 cycles after each accept.
- Wrap-around (MEM_SIZE=256): store 16'h1234 @0x00FF -> mem[0xFF]=34, mem[0x00]=12. Load @0x01FF (aliased) -> 16'h1234.
- Backpressure: load with rsp_ready low 10 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 all 10 cycles. Raise rsp_ready -> one handshake, then IDLE.
- Halt: halt_program high with req_valid high in IDLE -> never accepted. Halt raised during HI of a store -> the store completes, its response is delivered, and no further accept occurs.
- Reset mid-access: rst in HI of store 16'hAAAA @0x0040 -> no response, clear restarts, and load @0x0040 after clear -> 16'h0000.
